bench_seq_ctrl: RTL

BENCH_SEQ_CTRL -- requirements
Module: bench_seq_ctrl

---
 rtl/bench_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bench_seq_ctrl.sv
// Test sequencer for a 2-input/2-output FSM under test: resets it, drives LFSR stimulus,
// compacts its outputs into a MISR signature and compares that signature against a golden value.
module bench_seq_ctrl #(
   parameter int unsigned NUM_CYCLES = 256,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] golden,
   output logic        dut_rst_n,
   output logic        dut_in0,
   output logic        dut_in1,
   input  logic        dut_o0,
   input  logic        dut_o1,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature
);

   // An LFSR seed of zero would lock up, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [15:0] RUN_LAST = 16'(NUM_CYCLES - 1);
   localparam logic [15:0] POLY     = 16'h002D;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_DUT,
      S_RUN,
      S_FLUSH,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] misr_q, misr_d;
   logic        pass_q, pass_d;
   logic        active;

   function automatic logic [15:0] poly_shift(input logic [15:0] v);
      return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0000);
   endfunction

   // States in which abort is honoured; busy covers the same window.
   assign active = (state_q == S_RESET_DUT) || (state_q == S_RUN) ||
                   (state_q == S_FLUSH) || (state_q == S_COMPARE);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      pass_d  = pass_q;
      if (active && abort) begin
         state_d = S_IDLE;
         cnt_d   = 16'd0;
         pass_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               cnt_d = 16'd0;
               if (start) begin
                  state_d = S_RESET_DUT;
                  misr_d  = 16'h0000;
                  lfsr_d  = SEED_EFF;
                  pass_d  = 1'b0;
               end
            end
            S_RESET_DUT: begin
               if (cnt_q == 16'd1) begin
                  state_d = S_RUN;
                  cnt_d   = 16'd0;
               end
            end
            S_RUN: begin
               lfsr_d = poly_shift(lfsr_q);
               misr_d = poly_shift(misr_q) ^ {14'b0, dut_o1, dut_o0};
               if (cnt_q == RUN_LAST) begin
                  state_d = S_FLUSH;
                  cnt_d   = 16'd0;
               end
            end
            S_FLUSH: begin
               misr_d = poly_shift(misr_q) ^ {14'b0, dut_o1, dut_o0};
               if (cnt_q == 16'd1) begin
                  state_d = S_COMPARE;
                  cnt_d   = 16'd0;
               end
            end
            S_COMPARE: begin
               pass_d  = (misr_q == golden);
               state_d = S_DONE;
               cnt_d   = 16'd0;
            end
            S_DONE: begin
               state_d = S_IDLE;
               cnt_d   = 16'd0;
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = 16'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         lfsr_q  <= SEED_EFF;
         misr_q  <= 16'h0000;
         pass_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         pass_q  <= pass_d;
      end
   end

   // Outputs decode straight from registered state, so async reset reaches them immediately.
   assign busy      = active;
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign signature = misr_q;
   assign dut_rst_n = (state_q != S_IDLE) && (state_q != S_RESET_DUT);
   assign dut_in0   = (state_q == S_RUN) ? lfsr_q[0] : 1'b0;
   assign dut_in1   = (state_q == S_RUN) ? lfsr_q[1] : 1'b0;

endmodule
